// File: rtl/pow_5_result_checker.sv
// Scoreboard for pow_5 datapaths: queues accepted operands, compares in-order results
// against n^5 mod 2^w, and keeps sticky protocol flags plus saturating counters.
module pow_5_result_checker #(
  parameter int w     = 8,
  parameter int depth = 8,
  parameter int cnt_w = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     n_vld,
  input  logic [w-1:0]             n,
  input  logic                     res_vld,
  input  logic [w-1:0]             res,
  output logic                     mismatch,
  output logic [w-1:0]             expected,
  output logic [w-1:0]             got,
  output logic                     err,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(depth):0]   pending,
  output logic [cnt_w-1:0]         n_checked,
  output logic [cnt_w-1:0]         n_errors
);

  localparam int aw    = $clog2(depth);
  localparam int ptr_w = aw + 1;

  logic [w-1:0]     mem [depth];
  logic [ptr_w-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             mismatch_reg, err_reg, overflow_reg, underflow_reg;
  logic [w-1:0]     expected_reg, got_reg;
  logic [cnt_w-1:0] n_checked_reg, n_errors_reg;

  logic             full, empty, do_push, do_pop, is_bad;
  logic [w-1:0]     head;
  logic [w-1:0]     pow_chain [5];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[aw] != rd_ptr_reg[aw]) &&
                 (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]);

  // A pop in the same cycle frees the slot, so a full queue still accepts the operand.
  assign do_pop  = clk_en && res_vld && !empty;
  assign do_push = clk_en && n_vld && (!full || do_pop);

  // Head is read combinationally so the compare lands in the pop cycle.
  assign head = mem[rd_ptr_reg[aw-1:0]];
  assign pow_chain[0] = head;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pow
      assign pow_chain[gi+1] = pow_chain[gi] * head;
    end
  endgenerate

  assign is_bad = (pow_chain[4] != res);

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_ptr_reg[aw-1:0]] <= n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mismatch_reg  <= 1'b0;
      expected_reg  <= '0;
      got_reg       <= '0;
      err_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      n_checked_reg <= '0;
      n_errors_reg  <= '0;
    end else if (clk_en) begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
      if (do_pop) begin
        rd_ptr_reg   <= rd_ptr_reg + ptr_w'(1);
        expected_reg <= pow_chain[4];
        got_reg      <= res;
        mismatch_reg <= is_bad;
        if (~&n_checked_reg)
          n_checked_reg <= n_checked_reg + cnt_w'(1);
        if (is_bad) begin
          err_reg <= 1'b1;
          if (~&n_errors_reg)
            n_errors_reg <= n_errors_reg + cnt_w'(1);
        end
      end else begin
        mismatch_reg <= 1'b0;
      end
      if (n_vld && !do_push) begin
        overflow_reg <= 1'b1;
        err_reg      <= 1'b1;
      end
      if (res_vld && empty) begin
        underflow_reg <= 1'b1;
        err_reg       <= 1'b1;
      end
    end
  end

  assign pending   = wr_ptr_reg - rd_ptr_reg;
  assign mismatch  = mismatch_reg;
  assign expected  = expected_reg;
  assign got       = got_reg;
  assign err       = err_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign n_checked = n_checked_reg;
  assign n_errors  = n_errors_reg;

endmodule

// File: tb/tb_pow_5_result_checker.sv
// Directed test-plan steps followed by random traffic, every cycle checked against
// a queue-based reference model of the checker.
module tb_pow_5_result_checker;

  logic        clk = 1'b0;
  logic        rst, clk_en, n_vld, res_vld;
  logic [7:0]  n, res;
  logic        mismatch, err, overflow, underflow;
  logic [7:0]  expected, got;
  logic [3:0]  pending;
  logic [15:0] n_checked, n_errors;

  pow_5_result_checker #(.w(8), .depth(8), .cnt_w(16)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .n_vld(n_vld), .n(n),
    .res_vld(res_vld), .res(res), .mismatch(mismatch), .expected(expected),
    .got(got), .err(err), .overflow(overflow), .underflow(underflow),
    .pending(pending), .n_checked(n_checked), .n_errors(n_errors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_q[$];
  int m_mis, m_exp, m_got, m_err, m_ovf, m_unf, m_chk, m_errs;

  function automatic int pow5(int x);
    longint v;
    v = longint'(x);
    return int'((v * v * v * v * v) % 256);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mis = 0; m_exp = 0; m_got = 0; m_err = 0;
    m_ovf = 0; m_unf = 0; m_chk = 0; m_errs = 0;
  endtask

  task automatic model_step(bit r, bit en, bit nv, int nn, bit rv, int rr);
    bit pop, push;
    int h, e;
    if (r) begin
      model_reset();
      return;
    end
    if (!en) return;
    pop  = rv && (m_q.size() > 0);
    push = nv && (m_q.size() < 8 || pop);
    if (rv && m_q.size() == 0) begin m_unf = 1; m_err = 1; end
    if (nv && !push) begin m_ovf = 1; m_err = 1; end
    if (pop) begin
      h = m_q.pop_front();
      e = pow5(h);
      m_exp = e; m_got = rr; m_mis = (e != rr);
      if (m_chk < 65535) m_chk++;
      if (e != rr) begin
        m_err = 1;
        if (m_errs < 65535) m_errs++;
      end
    end else begin
      m_mis = 0;
    end
    if (push) m_q.push_back(nn);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pending"},   pending,   m_q.size());
    chk({tag, ".mismatch"},  mismatch,  m_mis);
    chk({tag, ".expected"},  expected,  m_exp);
    chk({tag, ".got"},       got,       m_got);
    chk({tag, ".err"},       err,       m_err);
    chk({tag, ".overflow"},  overflow,  m_ovf);
    chk({tag, ".underflow"}, underflow, m_unf);
    chk({tag, ".n_checked"}, n_checked, m_chk);
    chk({tag, ".n_errors"},  n_errors,  m_errs);
  endtask

  task automatic step(string tag, bit r, bit en, bit nv, int nn, bit rv, int rr);
    rst = r; clk_en = en; n_vld = nv; n = 8'(nn); res_vld = rv; res = 8'(rr);
    @(posedge clk);
    #1;
    model_step(r, en, nv, nn, rv, rr);
    check_all(tag);
  endtask

  initial begin
    int tn[4];
    int tr[4];
    model_reset();
    rst = 1'b1; clk_en = 1'b1; n_vld = 1'b0; res_vld = 1'b0; n = '0; res = '0;

    // reset state
    step("reset", 1, 1, 0, 0, 0, 0);
    chk("reset.pending0", pending, 0);

    // single operand
    step("single.push", 0, 1, 1, 3, 0, 0);
    step("single.wait", 0, 1, 0, 0, 0, 0);
    step("single.pop",  0, 1, 0, 0, 1, 243);
    chk("single.n_checked1", n_checked, 1);
    chk("single.no_mismatch", mismatch, 0);

    // truncation stream plus one wrong result
    tn = '{2, 5, 7, 4};
    tr = '{32, 53, 167, 0};
    for (int i = 0; i < 8; i++)
      step("trunc", 0, 1, i < 4, i < 4 ? tn[i] : 0, i >= 4, i >= 4 ? tr[i-4] : 0);
    chk("trunc.no_errors", n_errors, 0);
    step("wrong.push", 0, 1, 1, 7, 0, 0);
    step("wrong.pop",  0, 1, 0, 0, 1, 166);
    chk("wrong.mismatch", mismatch, 1);
    chk("wrong.expected", expected, 167);
    chk("wrong.got", got, 166);
    step("wrong.after", 0, 1, 0, 0, 0, 0);
    chk("wrong.pulse_gone", mismatch, 0);
    chk("wrong.err_sticky", err, 1);

    // full queue with simultaneous push and pop, then overflow
    step("full.reset", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("full.fill", 0, 1, 1, i + 10, 0, 0);
    chk("full.pending8", pending, 8);
    step("full.swap", 0, 1, 1, 99, 1, pow5(10));
    chk("full.swap_pending", pending, 8);
    chk("full.swap_no_ovf", overflow, 0);
    step("full.ovf", 0, 1, 1, 55, 0, 0);
    chk("full.ovf_set", overflow, 1);
    chk("full.ovf_pending", pending, 8);

    // underflow with a same-cycle push
    step("unf.reset", 1, 1, 0, 0, 0, 0);
    step("unf.both", 0, 1, 1, 6, 1, 0);
    chk("unf.flag", underflow, 1);
    chk("unf.pending1", pending, 1);
    step("unf.pop", 0, 1, 0, 0, 1, pow5(6));
    chk("unf.n_checked1", n_checked, 1);

    // clk_en gating
    step("gate.push", 0, 1, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step("gate.off", 0, 0, 1, 4, 1, 17);
    chk("gate.pending", pending, 1);

    // reset mid-flight
    step("mid.push", 0, 1, 1, 1, 0, 0);
    step("mid.push", 0, 1, 1, 2, 0, 0);
    chk("mid.pending3", pending, 3);
    step("mid.reset", 1, 1, 1, 3, 1, 0);
    step("mid.late_res", 0, 1, 0, 0, 1, pow5(9));
    chk("mid.underflow", underflow, 1);

    // random traffic
    step("rand.reset", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit r, en, nv, rv;
      int nn, rr;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      nv = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 2) != 0);
      nn = $urandom_range(0, 255);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
        rr = pow5(m_q[0]);
      else
        rr = $urandom_range(0, 255);
      step("rand", r, en, nv, nn, rv, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
